// File: rtl/axis_pipe_arbiter_pkg.sv
// Shared types and helpers for the pipe arbiter: tag width, arbiter state,
// and the round-robin grant search.
package axis_pipe_arbiter_pkg;

  localparam int unsigned MAX_PORTS = 16;

  typedef enum logic {
    IDLE,
    PASS
  } arb_state_t;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // First valid port strictly after 'last', wrapping within n ports; keeps 'last' if none valid.
  function automatic logic [3:0] rr_next(input logic [MAX_PORTS-1:0] valid,
                                         input logic [3:0]           last,
                                         input int unsigned          n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
      if (i <= n && !found) begin
        idx = (32'(last) + i) % n;
        if (valid[idx]) begin
          pick  = 4'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_pipe_arb_tag_fifo.sv
// Source-port tag FIFO: one entry per packet in flight inside the shared pipe,
// first-word-fall-through head.
module axis_pipe_arb_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_pipe_arbiter.sv
// Shares one in-order fixed-latency AXI-Stream pipe between NUM_PORTS requesters:
// packet-granular round-robin on the way in, tag-FIFO demux on the way out.
module axis_pipe_arbiter
  import axis_pipe_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_PKTS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS*WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]         s_axis_tlast,
  input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
  output logic [NUM_PORTS-1:0]         s_axis_tready,
  output logic [WIDTH-1:0]             pipe_in_tdata,
  output logic                         pipe_in_tlast,
  output logic                         pipe_in_tvalid,
  input  logic                         pipe_in_tready,
  input  logic [WIDTH-1:0]             pipe_out_tdata,
  input  logic                         pipe_out_tlast,
  input  logic                         pipe_out_tvalid,
  output logic                         pipe_out_tready,
  output logic [NUM_PORTS*WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_PORTS-1:0]         m_axis_tlast,
  output logic [NUM_PORTS-1:0]         m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]         m_axis_tready,
  output logic [$clog2(MAX_PKTS):0]    inflight_pkts,
  output logic                         err_no_tag
);

  localparam int unsigned TW = tag_w(NUM_PORTS);

  arb_state_t           state_q, state_d;
  logic [TW-1:0]        grant_q, last_grant_q, next_grant, head;
  logic [MAX_PORTS-1:0] valid_ext;
  logic                 first_beat_q, err_q;
  logic                 any_valid, sel_valid, sel_last, stall, in_hs;
  logic                 fifo_full, fifo_empty, push, pop;

  assign any_valid = |s_axis_tvalid;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_PORTS-1:0] = s_axis_tvalid;
    next_grant = TW'(rr_next(valid_ext, 4'(last_grant_q), NUM_PORTS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = PASS;
      PASS:    if (in_hs && pipe_in_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid is gated with the stall as well as ready, so the pipe never takes
  // a first beat whose tag could not be recorded.
  always_comb begin
    sel_valid      = s_axis_tvalid[grant_q];
    sel_last       = s_axis_tlast[grant_q];
    stall          = first_beat_q & fifo_full;
    pipe_in_tdata  = s_axis_tdata[32'(grant_q)*WIDTH +: WIDTH];
    pipe_in_tlast  = sel_last;
    pipe_in_tvalid = 1'b0;
    s_axis_tready  = '0;
    if (state_q == PASS) begin
      pipe_in_tvalid         = sel_valid & ~stall;
      s_axis_tready[grant_q] = pipe_in_tready & ~stall;
    end
  end

  assign in_hs = pipe_in_tvalid & pipe_in_tready;
  assign push  = in_hs & first_beat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q      <= '0;
      last_grant_q <= TW'(NUM_PORTS - 1);
      first_beat_q <= 1'b0;
    end else begin
      if (state_q == IDLE && any_valid) begin
        grant_q      <= next_grant;
        first_beat_q <= 1'b1;
      end else if (in_hs) begin
        first_beat_q <= 1'b0;
      end
      if (in_hs && pipe_in_tlast) last_grant_q <= grant_q;
    end
  end

  axis_pipe_arb_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_PKTS)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (grant_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight_pkts),
    .head      (head)
  );

  assign m_axis_tdata = {NUM_PORTS{pipe_out_tdata}};
  assign m_axis_tlast = {NUM_PORTS{pipe_out_tlast}};

  // With no tag pending the pipe output is drained and dropped.
  always_comb begin
    m_axis_tvalid   = '0;
    pipe_out_tready = 1'b1;
    if (!fifo_empty) begin
      pipe_out_tready     = m_axis_tready[head];
      m_axis_tvalid[head] = pipe_out_tvalid;
    end
  end

  assign pop = pipe_out_tvalid & pipe_out_tready & pipe_out_tlast & ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               err_q <= 1'b0;
    else if (pipe_out_tvalid && fifo_empty)  err_q <= 1'b1;
  end

  assign err_no_tag = err_q;

endmodule

// File: tb/tb_axis_pipe_arbiter.sv
// Bench for axis_pipe_arbiter: elastic 3-cycle pipe model, queue scoreboard
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axis_pipe_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned M  = 2;
  localparam int unsigned CW = $clog2(M) + 1;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic           clk, reset;
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [W-1:0]   pipe_in_tdata, pipe_out_tdata;
  logic           pipe_in_tlast, pipe_in_tvalid, pipe_in_tready;
  logic           pipe_out_tlast, pipe_out_tvalid, pipe_out_tready;
  logic [N*W-1:0] m_axis_tdata;
  logic [N-1:0]   m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [CW-1:0]  inflight_pkts;
  logic           err_no_tag;

  axis_pipe_arbiter #(.WIDTH(W), .NUM_PORTS(N), .MAX_PKTS(M)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .pipe_in_tdata(pipe_in_tdata), .pipe_in_tlast(pipe_in_tlast),
    .pipe_in_tvalid(pipe_in_tvalid), .pipe_in_tready(pipe_in_tready),
    .pipe_out_tdata(pipe_out_tdata), .pipe_out_tlast(pipe_out_tlast),
    .pipe_out_tvalid(pipe_out_tvalid), .pipe_out_tready(pipe_out_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .inflight_pkts(inflight_pkts), .err_no_tag(err_no_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared pipe stand-in: 3 stages, fixed latency when flowing, bubbles collapse under stall.
  logic         bypass, byp_v, byp_l;
  logic [W-1:0] byp_d;
  logic [2:0]   pv, pl;
  logic [W-1:0] pd [3];
  logic         en0, en1, en2;

  assign en2             = ~pv[2] | (pipe_out_tready & ~bypass);
  assign en1             = ~pv[1] | en2;
  assign en0             = ~pv[0] | en1;
  assign pipe_in_tready  = ~bypass & en0;
  assign pipe_out_tvalid = bypass ? byp_v : pv[2];
  assign pipe_out_tdata  = bypass ? byp_d : pd[2];
  assign pipe_out_tlast  = bypass ? byp_l : pl[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      pl <= '0;
    end else begin
      if (en2) begin pv[2] <= pv[1]; pd[2] <= pd[1]; pl[2] <= pl[1]; end
      if (en1) begin pv[1] <= pv[0]; pd[1] <= pd[0]; pl[1] <= pl[0]; end
      if (en0) begin
        pv[0] <= pipe_in_tvalid & pipe_in_tready;
        pd[0] <= pipe_in_tdata;
        pl[0] <= pipe_in_tlast;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  beat_t        src_q [N][$];
  beat_t        exp_q [N][$];
  logic [W-1:0] out_log [N][$];
  int           grant_log[$], first_cyc[$], last_cyc[$], tag_q[$], infl_trace[$];
  int unsigned  acc_cnt [N];
  int unsigned  drv_cnt [N];
  int           model_cnt, open_port, cyc;
  bit           model_err, open;
  logic [CW-1:0] last_infl;

  initial begin
    for (int p = 0; p < N; p++) begin acc_cnt[p] = 0; drv_cnt[p] = 0; end
    model_cnt = 0; model_err = 0; open = 0; open_port = 0; cyc = 0; last_infl = '0;
  end

  // Source driver: retire accepted beats, present the next head of each port queue.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < N; p++) begin
      if (reset) begin
        src_q[p].delete();
        drv_cnt[p] = acc_cnt[p];
      end else begin
        while (drv_cnt[p] < acc_cnt[p]) begin
          if (src_q[p].size() > 0) src_q[p].delete(0);
          drv_cnt[p]++;
        end
      end
      if (src_q[p].size() > 0) begin
        s_axis_tvalid[p]        = 1'b1;
        s_axis_tdata[p*W +: W]  = src_q[p][0].d;
        s_axis_tlast[p]         = src_q[p][0].l;
      end else begin
        s_axis_tvalid[p]        = 1'b0;
        s_axis_tdata[p*W +: W]  = '0;
        s_axis_tlast[p]         = 1'b0;
      end
    end
  end

  // Scoreboard: every beat accepted from port p must come out on m port p, in order.
  always @(negedge clk) begin
    int    h, hp, hs_n;
    beat_t e, b;
    if (reset) begin
      for (int p = 0; p < N; p++) exp_q[p].delete();
      tag_q.delete();
      model_cnt = 0; model_err = 0; open = 0; last_infl = '0;
    end else begin
      cyc++;
      chk("inflight", 32'(inflight_pkts), 32'(model_cnt));
      if (inflight_pkts != last_infl) begin
        infl_trace.push_back(int'(inflight_pkts));
        last_infl = inflight_pkts;
      end
      chk("err_no_tag", 32'(err_no_tag), 32'(model_err));
      chk("ready_onehot", 32'($countones(s_axis_tready) <= 1), 32'(1));
      if (pipe_out_tvalid) begin
        if (tag_q.size() == 0) begin
          chk("m_valid_notag", 32'(m_axis_tvalid), 32'(0));
          chk("out_ready_notag", 32'(pipe_out_tready), 32'(1));
          model_err = 1;
        end else begin
          h = tag_q[0];
          chk("m_valid", 32'(m_axis_tvalid), 32'(1) << h);
          chk("out_ready", 32'(pipe_out_tready), 32'(m_axis_tready[h]));
          chk("m_data_fan", 32'(m_axis_tdata[h*W +: W]), 32'(pipe_out_tdata));
          chk("m_last_fan", 32'(m_axis_tlast[h]), 32'(pipe_out_tlast));
          if (pipe_out_tready) begin
            if (exp_q[h].size() == 0) begin
              chk("unexpected_beat", 32'(pipe_out_tdata), 32'hFFFF_FFFF);
            end else begin
              e = exp_q[h].pop_front();
              chk("m_data", 32'(pipe_out_tdata), 32'(e.d));
              chk("m_last", 32'(pipe_out_tlast), 32'(e.l));
              out_log[h].push_back(pipe_out_tdata);
              if (e.l) begin
                void'(tag_q.pop_front());
                model_cnt--;
              end
            end
          end
        end
      end else begin
        chk("m_valid_idle", 32'(m_axis_tvalid), 32'(0));
      end
      hs_n = 0; hp = 0;
      for (int p = 0; p < N; p++)
        if (s_axis_tvalid[p] && s_axis_tready[p]) begin hs_n++; hp = p; end
      chk("in_handshake", 32'(hs_n != 0), 32'(pipe_in_tvalid && pipe_in_tready));
      if (hs_n == 1) begin
        chk("pipe_in_data", 32'(pipe_in_tdata), 32'(s_axis_tdata[hp*W +: W]));
        chk("pipe_in_last", 32'(pipe_in_tlast), 32'(s_axis_tlast[hp]));
        b.d = s_axis_tdata[hp*W +: W];
        b.l = s_axis_tlast[hp];
        exp_q[hp].push_back(b);
        acc_cnt[hp]++;
        if (!open) begin
          open = 1; open_port = hp;
          grant_log.push_back(hp);
          first_cyc.push_back(cyc);
          tag_q.push_back(hp);
          model_cnt++;
        end else begin
          chk("pkt_port", 32'(hp), 32'(open_port));
        end
        if (b.l) begin
          open = 0;
          last_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input int p, input int n, input logic [W-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + W'(i);
      b.l = (i == n - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      done = (tag_q.size() == 0) && !open && !pipe_out_tvalid;
      for (int p = 0; p < N; p++)
        if (src_q[p].size() != 0 || exp_q[p].size() != 0) done = 0;
    end
    chk(name, 32'(done), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    for (int p = 0; p < N; p++) out_log[p].delete();
    grant_log.delete(); first_cyc.delete(); last_cyc.delete(); infl_trace.delete();
  endtask

  initial begin
    int base2;
    reset = 1'b1;
    m_axis_tready = '1;
    bypass = 1'b0; byp_v = 1'b0; byp_l = 1'b0; byp_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_axis_tready), 32'(0));
    chk("rst_pipe_valid", 32'(pipe_in_tvalid), 32'(0));
    chk("rst_m_valid", 32'(m_axis_tvalid), 32'(0));
    chk("rst_inflight", 32'(inflight_pkts), 32'(0));
    chk("rst_err", 32'(err_no_tag), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // 1: single 3-beat packet on port 0
    clear_logs();
    send(0, 3, 16'h0000);
    wait_drain("t1_drain");
    chk("t1_len", 32'(out_log[0].size()), 32'(3));
    for (int i = 0; i < 3 && i < out_log[0].size(); i++) chk("t1_data", 32'(out_log[0][i]), 32'(i));
    chk("t1_others", 32'(out_log[1].size() + out_log[2].size() + out_log[3].size()), 32'(0));
    chk("t1_trace_len", 32'(infl_trace.size()), 32'(2));
    if (infl_trace.size() == 2) begin
      chk("t1_trace0", 32'(infl_trace[0]), 32'(1));
      chk("t1_trace1", 32'(infl_trace[1]), 32'(0));
    end

    // 2: ports 0..2 each send two 2-beat packets; last grant was port 0
    clear_logs();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 2; k++) send(p, 2, {8'(p), 8'(2*k)});
    wait_drain("t2_drain");
    chk("t2_npkts", 32'(grant_log.size()), 32'(6));
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("t2_order", 32'(grant_log[k]), 32'((k + 1) % 3));
    for (int k = 0; k < 5 && k + 1 < first_cyc.size() && k < last_cyc.size(); k++)
      chk("t2_bubble", 32'(first_cyc[k+1] - last_cyc[k]), 32'(2));
    for (int p = 0; p < 3; p++) begin
      chk("t2_len", 32'(out_log[p].size()), 32'(4));
      for (int s = 0; s < 4 && s < out_log[p].size(); s++) chk("t2_data", 32'(out_log[p][s]), 32'({8'(p), 8'(s)}));
    end
    chk("t2_port3", 32'(out_log[3].size()), 32'(0));

    // 3: head-of-line block on port 1
    clear_logs();
    m_axis_tready = 4'b1101;
    send(1, 4, 16'h1100);
    for (int i = 0; i < 50 && grant_log.size() == 0; i++) @(negedge clk);
    chk("t3_granted", 32'(grant_log.size()), 32'(1));
    send(0, 2, 16'h0A00);
    for (int i = 0; i < 50 && !pipe_out_tvalid; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("t3_out_ready", 32'(pipe_out_tready), 32'(0));
    chk("t3_in_ready", 32'(pipe_in_tready), 32'(0));
    chk("t3_p0_blocked", 32'(out_log[0].size()), 32'(0));
    m_axis_tready = '1;
    wait_drain("t3_drain");
    chk("t3_p1_len", 32'(out_log[1].size()), 32'(4));
    chk("t3_p0_len", 32'(out_log[0].size()), 32'(2));
    if (out_log[1].size() == 4) chk("t3_p1_last", 32'(out_log[1][3]), 32'h1103);
    if (out_log[0].size() == 2) chk("t3_p0_last", 32'(out_log[0][1]), 32'h0A01);

    // 4: FIFO full back-pressure with single-beat packets on port 3
    clear_logs();
    m_axis_tready = 4'b0111;
    for (int k = 0; k < 3; k++) send(3, 1, 16'h3300 + 16'(k));
    for (int i = 0; i < 50 && model_cnt != 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t4_inflight_full", 32'(inflight_pkts), 32'(2));
    chk("t4_ready_blocked", 32'(s_axis_tready[3]), 32'(0));
    chk("t4_pipe_valid_blocked", 32'(pipe_in_tvalid), 32'(0));
    @(posedge clk);
    #1 m_axis_tready = '1;
    @(negedge clk);
    chk("t4_ready_pop_cycle", 32'(s_axis_tready[3]), 32'(0));
    @(negedge clk);
    chk("t4_ready_after_pop", 32'(s_axis_tready[3]), 32'(1));
    wait_drain("t4_drain");
    chk("t4_len", 32'(out_log[3].size()), 32'(3));

    // 5: pipe output with no tag pending
    @(posedge clk);
    #1;
    bypass = 1'b1; byp_v = 1'b1; byp_d = 16'hDEAD; byp_l = 1'b1;
    @(negedge clk);
    chk("t5_out_ready", 32'(pipe_out_tready), 32'(1));
    chk("t5_m_valid", 32'(m_axis_tvalid), 32'(0));
    chk("t5_err_before", 32'(err_no_tag), 32'(0));
    @(posedge clk);
    #1 byp_v = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(err_no_tag), 32'(1));
    repeat (5) @(negedge clk);
    chk("t5_err_sticky", 32'(err_no_tag), 32'(1));
    bypass = 1'b0;
    @(negedge clk);

    // 6: reset mid-packet on port 2, then port 0 wins first
    clear_logs();
    base2 = int'(acc_cnt[2]);
    send(2, 4, 16'h2200);
    for (int i = 0; i < 50 && int'(acc_cnt[2]) < base2 + 2; i++) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6_s_ready", 32'(s_axis_tready), 32'(0));
    chk("t6_pipe_valid", 32'(pipe_in_tvalid), 32'(0));
    chk("t6_m_valid", 32'(m_axis_tvalid), 32'(0));
    chk("t6_inflight", 32'(inflight_pkts), 32'(0));
    chk("t6_err_clr", 32'(err_no_tag), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
    send(0, 2, 16'h0B00);
    send(2, 2, 16'h2B00);
    wait_drain("t6_drain");
    chk("t6_npkts", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      chk("t6_first", 32'(grant_log[0]), 32'(0));
      chk("t6_second", 32'(grant_log[1]), 32'(2));
    end
    chk("t6_p2_len", 32'(out_log[2].size()), 32'(2));
    if (out_log[2].size() == 2) chk("t6_p2_data", 32'(out_log[2][0]), 32'h2B00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
